// File: rtl/mpmc10_pkg.sv
`default_nettype none
// =============================================================================
// mpmc10_pkg : shared types and default constants for the mpmc10 response path
// Rev 1.0
// =============================================================================
package mpmc10_pkg;

    localparam int NPORT_DEF     = 8;
    localparam int DEPTH_DEF     = 4;
    localparam int STALL_LIM_DEF = 255;

    typedef struct packed {
        logic [3:0]   port;
        logic [7:0]   tid;
        logic         err;
        logic [255:0] data;
    } mpmc10_resp_t;

    // Generic FIFO entry wrapper used by other mpmc10 queues.
    typedef struct packed {
        logic         valid;
        mpmc10_resp_t resp;
    } mpmc10_fifoe_t;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

endpackage
`default_nettype wire

// File: rtl/mpmc10_resp_fifo.sv
`default_nettype none
// =============================================================================
// mpmc10_resp_fifo : power-of-two response FIFO with wrapping pointers
// Rev 1.0
// =============================================================================
module mpmc10_resp_fifo
    import mpmc10_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  mpmc10_resp_t             din,
    output mpmc10_resp_t             dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    mpmc10_resp_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: count gates every read.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule
`default_nettype wire

// File: rtl/mpmc10_resp_dispatch.sv
`default_nettype none
// =============================================================================
// mpmc10_resp_dispatch : in-order response FIFO feeding per-port hold slots
// Rev 1.0
// =============================================================================
module mpmc10_resp_dispatch
    import mpmc10_pkg::*;
#(
    parameter int NPORT     = NPORT_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    parameter int STALL_LIM = STALL_LIM_DEF
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               in_valid_i,
    input  mpmc10_resp_t       in_resp_i,
    output logic               in_ready_o,
    output logic [NPORT-1:0]   port_valid_o,
    output mpmc10_resp_t       port_resp_o [NPORT],
    input  logic [NPORT-1:0]   port_ack_i,
    output logic               bad_port_o,
    output logic               stall_o,
    input  logic               stall_clr_i
);
    localparam int              CW          = $clog2(DEPTH) + 1;
    localparam int              SW          = $clog2(STALL_LIM + 2);
    localparam logic [4:0]      NPORT_L     = 5'(NPORT);
    localparam logic [SW-1:0]   STALL_LIM_L = SW'(STALL_LIM);

    mpmc10_resp_t  head;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          accept;
    logic          port_ok;
    logic          push;
    logic          dispatch;
    logic [15:0]   slot_free;
    logic [SW-1:0] stall_cnt;
    logic [SW-1:0] stall_cnt_nxt;
    logic          stall_set;

    assign in_ready_o = rst_ni && !full;
    assign accept     = in_valid_i && in_ready_o;
    assign port_ok    = ({1'b0, in_resp_i.port} < NPORT_L);
    assign push       = accept && port_ok;

    // A slot can take the head if it is empty or is being acked this cycle.
    always_comb begin
        slot_free = '0;
        for (int p = 0; p < NPORT; p++) begin
            slot_free[p] = !port_valid_o[p] || port_ack_i[p];
        end
    end

    assign dispatch = !empty && slot_free[head.port];

    mpmc10_resp_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .push  (push),
        .pop   (dispatch),
        .din   (in_resp_i),
        .dout  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    for (genvar p = 0; p < NPORT; p++) begin : g_slot
        slot_state_t state;
        logic        sel;

        assign sel = dispatch && (head.port == 4'(p));

        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                state <= SLOT_EMPTY;
            end else begin
                case (state)
                    SLOT_EMPTY: if (sel) state <= SLOT_FULL;
                    SLOT_FULL:  if (!sel && port_ack_i[p]) state <= SLOT_EMPTY;
                    default:    state <= SLOT_EMPTY;
                endcase
            end
        end

        always_ff @(posedge clk_i) begin
            if (sel) port_resp_o[p] <= head;
        end

        assign port_valid_o[p] = (state == SLOT_FULL);
    end

    // Saturating head-of-line wait counter.
    always_comb begin
        stall_cnt_nxt = stall_cnt;
        if (count == '0 || dispatch) begin
            stall_cnt_nxt = '0;
        end else if (stall_cnt != '1) begin
            stall_cnt_nxt = stall_cnt + SW'(1);
        end
    end

    assign stall_set = (stall_cnt_nxt > STALL_LIM_L);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            stall_cnt  <= '0;
            stall_o    <= 1'b0;
            bad_port_o <= 1'b0;
        end else begin
            stall_cnt  <= stall_cnt_nxt;
            bad_port_o <= accept && !port_ok;
            if (stall_set) begin
                stall_o <= 1'b1;
            end else if (stall_clr_i) begin
                stall_o <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mpmc10_resp_dispatch.sv
`default_nettype none
// tb_mpmc10_resp_dispatch : directed scenarios plus randomized traffic
// compared against a queue-based behavioural model of the dispatcher.
module tb_mpmc10_resp_dispatch;
    import mpmc10_pkg::*;

    localparam int NPORT     = 8;
    localparam int DEPTH     = 4;
    localparam int STALL_LIM = 255;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             in_valid  = 1'b0;
    logic             stall_clr = 1'b0;
    mpmc10_resp_t     in_resp   = '0;
    logic [NPORT-1:0] port_ack  = '0;
    logic             in_ready;
    logic             bad_port;
    logic             stall;
    logic [NPORT-1:0] port_valid;
    mpmc10_resp_t     port_resp [NPORT];

    int checks = 0;
    int errors = 0;

    // Reference model state
    mpmc10_resp_t     mq[$];
    logic [NPORT-1:0] m_valid = '0;
    mpmc10_resp_t     m_resp [NPORT];
    logic             m_bad   = 1'b0;
    logic             m_stall = 1'b0;
    int               m_scnt  = 0;

    mpmc10_resp_dispatch #(
        .NPORT     (NPORT),
        .DEPTH     (DEPTH),
        .STALL_LIM (STALL_LIM)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .in_valid_i   (in_valid),
        .in_resp_i    (in_resp),
        .in_ready_o   (in_ready),
        .port_valid_o (port_valid),
        .port_resp_o  (port_resp),
        .port_ack_i   (port_ack),
        .bad_port_o   (bad_port),
        .stall_o      (stall),
        .stall_clr_i  (stall_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_step();
        bit acc;
        bit disp;
        int hp;
        acc  = 0;
        disp = 0;
        hp   = 0;
        if (!rst_n) begin
            mq.delete();
            m_valid = '0;
            m_bad   = 1'b0;
            m_stall = 1'b0;
            m_scnt  = 0;
            return;
        end
        acc = in_valid && (mq.size() < DEPTH);
        if (mq.size() > 0) begin
            hp   = int'(mq[0].port);
            disp = !m_valid[hp] || port_ack[hp];
        end
        if (mq.size() == 0 || disp) m_scnt = 0;
        else                        m_scnt = m_scnt + 1;
        if (m_scnt > STALL_LIM)  m_stall = 1'b1;
        else if (stall_clr)      m_stall = 1'b0;
        for (int p = 0; p < NPORT; p++) begin
            if (disp && hp == p) begin
                m_valid[p] = 1'b1;
                m_resp[p]  = mq[0];
            end else if (port_ack[p]) begin
                m_valid[p] = 1'b0;
            end
        end
        if (disp) void'(mq.pop_front());
        m_bad = acc && (int'(in_resp.port) >= NPORT);
        if (acc && int'(in_resp.port) < NPORT) mq.push_back(in_resp);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    function automatic mpmc10_resp_t rand_resp(input logic [3:0] port, input logic [7:0] tid);
        mpmc10_resp_t r;
        r.port = port;
        r.tid  = tid;
        r.err  = 1'($urandom);
        for (int i = 0; i < 8; i++) r.data[i*32 +: 32] = $urandom();
        return r;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; port_ack = '0;
        tick(); tick();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", in_ready); end
        checks++; if (port_valid !== '0) begin errors++; $display("FAIL reset_valid: got %h expected 00", port_valid); end
        checks++; if (bad_port !== 1'b0) begin errors++; $display("FAIL reset_bad: got %b expected 0", bad_port); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall); end
        rst_n = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_single();
        mpmc10_resp_t exp;
        exp = '{port: 4'd3, tid: 8'h5A, err: 1'b0, data: {32{8'hA5}}};
        in_valid = 1'b1; in_resp = exp;
        tick();
        in_valid = 1'b0;
        checks++; if (port_valid !== 8'h00) begin errors++; $display("FAIL single_early: got %h expected 00", port_valid); end
        tick();
        checks++; if (port_valid !== 8'h08) begin errors++; $display("FAIL single_valid: got %h expected 08", port_valid); end
        checks++; if (port_resp[3] !== exp) begin errors++; $display("FAIL single_data: got tid %h data %h expected tid 5a data all a5", port_resp[3].tid, port_resp[3].data); end
        port_ack = 8'h08;
        tick();
        port_ack = '0;
        checks++; if (port_valid !== 8'h00) begin errors++; $display("FAIL single_ack: got %h expected 00", port_valid); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] got[$];
        bit order_ok;
        port_ack = '1;
        for (int t = 1; t <= 8; t++) begin
            if (t <= 4) begin
                in_valid = 1'b1;
                in_resp  = rand_resp(4'(t - 1), 8'(8'h30 + t - 1));
                checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready t=%0d: got %b expected 1", t, in_ready); end
            end else begin
                in_valid = 1'b0;
            end
            tick();
            checks++;
            if ($countones(port_valid) !== ((t >= 2 && t <= 5) ? 1 : 0)) begin
                errors++; $display("FAIL b2b_rate t=%0d: got valid %h expected %0d bits", t, port_valid, (t >= 2 && t <= 5) ? 1 : 0);
            end
            for (int p = 0; p < NPORT; p++) if (port_valid[p]) got.push_back(port_resp[p].tid);
        end
        order_ok = (got.size() == 4);
        for (int i = 0; i < got.size() && i < 4; i++) if (got[i] !== 8'(8'h30 + i)) order_ok = 0;
        checks++; if (!order_ok) begin errors++; $display("FAIL b2b_order: got %0d tids %p expected 30 31 32 33", got.size(), got); end
        port_ack = '0;
    endtask

    task automatic test_hol_stall();
        logic [3:0] ports [5] = '{4'd2, 4'd2, 4'd5, 4'd5, 4'd5};
        logic [7:0] tids  [5] = '{8'h10, 8'h11, 8'h20, 8'h21, 8'h22};
        port_ack = '0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_resp = rand_resp(ports[i], tids[i]);
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL hol_accept %0d: got ready %b expected 1", i, in_ready); end
            tick();
        end
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hol_full: got ready %b expected 0", in_ready); end
        checks++; if (port_valid !== 8'h04 || port_resp[2].tid !== 8'h10) begin errors++; $display("FAIL hol_slot: got %h tid %h expected 04 tid 10", port_valid, port_resp[2].tid); end
        for (int c = 0; c < 300; c++) begin
            tick();
            checks++; if (stall !== m_stall) begin errors++; $display("FAIL hol_stall c=%0d waited=%0d: got %b expected %b", c, m_scnt, stall, m_stall); end
        end
        checks++; if (stall !== 1'b1 || port_valid !== 8'h04) begin errors++; $display("FAIL hol_blocked: got stall %b valid %h expected 1 04", stall, port_valid); end
        stall_clr = 1'b1;
        tick();
        stall_clr = 1'b0;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL hol_set_wins: got %b expected 1", stall); end
        port_ack = 8'h04;
        tick();
        port_ack = '0;
        checks++; if (port_valid !== 8'h04 || port_resp[2].tid !== 8'h11) begin errors++; $display("FAIL hol_resume: got %h tid %h expected 04 tid 11", port_valid, port_resp[2].tid); end
        port_ack = '1;
        for (int c = 0; c < 6; c++) begin
            tick();
            checks++; if (port_valid !== m_valid) begin errors++; $display("FAIL hol_drain c=%0d: got %h expected %h", c, port_valid, m_valid); end
            for (int p = 0; p < NPORT; p++) if (m_valid[p]) begin
                checks++; if (port_resp[p] !== m_resp[p]) begin errors++; $display("FAIL hol_drain_data p=%0d: got tid %h expected %h", p, port_resp[p].tid, m_resp[p].tid); end
            end
        end
        port_ack = '0;
        checks++; if (port_valid !== 8'h00 || in_ready !== 1'b1) begin errors++; $display("FAIL hol_empty: got %h ready %b expected 00 1", port_valid, in_ready); end
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL hol_sticky: got %b expected 1", stall); end
        stall_clr = 1'b1;
        tick();
        stall_clr = 1'b0;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL hol_clear: got %b expected 0", stall); end
    endtask

    task automatic test_bad_port();
        in_valid = 1'b1; in_resp = rand_resp(4'd9, 8'h77);
        tick();
        in_valid = 1'b0;
        checks++; if (bad_port !== 1'b1) begin errors++; $display("FAIL bad_pulse: got %b expected 1", bad_port); end
        tick();
        checks++; if (bad_port !== 1'b0) begin errors++; $display("FAIL bad_width: got %b expected 0", bad_port); end
        tick();
        checks++; if (port_valid !== 8'h00 || in_ready !== 1'b1) begin errors++; $display("FAIL bad_dropped: got %h ready %b expected 00 1", port_valid, in_ready); end
    endtask

    task automatic test_ack_dispatch();
        port_ack = '0;
        in_valid = 1'b1; in_resp = rand_resp(4'd4, 8'h41);
        tick();
        in_resp = rand_resp(4'd4, 8'h42);
        tick();
        in_valid = 1'b0;
        tick();
        checks++; if (port_valid !== 8'h10 || port_resp[4].tid !== 8'h41) begin errors++; $display("FAIL ackdisp_first: got %h tid %h expected 10 tid 41", port_valid, port_resp[4].tid); end
        port_ack = 8'h10;
        tick();
        checks++; if (port_valid !== 8'h10 || port_resp[4].tid !== 8'h42) begin errors++; $display("FAIL ackdisp_reload: got %h tid %h expected 10 tid 42", port_valid, port_resp[4].tid); end
        tick();
        port_ack = '0;
        checks++; if (port_valid !== 8'h00) begin errors++; $display("FAIL ackdisp_empty: got %h expected 00", port_valid); end
    endtask

    task automatic test_reset_mid();
        logic [3:0] ports [5] = '{4'd0, 4'd1, 4'd0, 4'd1, 4'd1};
        bit clean;
        port_ack = '0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_resp = rand_resp(ports[i], 8'(8'h60 + i));
            tick();
        end
        in_valid = 1'b0;
        checks++; if (port_valid !== 8'h03) begin errors++; $display("FAIL midrst_pre: got %h expected 03", port_valid); end
        rst_n = 1'b0;
        tick();
        checks++; if (port_valid !== 8'h00 || bad_port !== 1'b0 || stall !== 1'b0 || in_ready !== 1'b0) begin
            errors++; $display("FAIL midrst_zero: got valid %h bad %b stall %b ready %b expected 00 0 0 0", port_valid, bad_port, stall, in_ready);
        end
        rst_n = 1'b1;
        clean = 1;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (port_valid !== 8'h00) clean = 0;
        end
        checks++; if (!clean || in_ready !== 1'b1) begin errors++; $display("FAIL midrst_stale: got valid %h ready %b expected 00 1", port_valid, in_ready); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_resp   = rand_resp(4'($urandom_range(0, 9)), 8'($urandom()));
            port_ack  = (c % 200 < 100) ? NPORT'($urandom()) : NPORT'($urandom() & $urandom() & $urandom());
            stall_clr = ($urandom_range(0, 31) == 0);
            tick();
            checks++; if (in_ready !== (mq.size() < DEPTH)) begin errors++; $display("FAIL rnd_ready c=%0d: got %b expected %b", c, in_ready, mq.size() < DEPTH); end
            checks++; if (port_valid !== m_valid) begin errors++; $display("FAIL rnd_valid c=%0d: got %h expected %h", c, port_valid, m_valid); end
            checks++; if (bad_port !== m_bad) begin errors++; $display("FAIL rnd_bad c=%0d: got %b expected %b", c, bad_port, m_bad); end
            checks++; if (stall !== m_stall) begin errors++; $display("FAIL rnd_stall c=%0d: got %b expected %b", c, stall, m_stall); end
            for (int p = 0; p < NPORT; p++) if (m_valid[p]) begin
                checks++; if (port_resp[p] !== m_resp[p]) begin errors++; $display("FAIL rnd_data c=%0d p=%0d: got tid %h err %b expected tid %h err %b", c, p, port_resp[p].tid, port_resp[p].err, m_resp[p].tid, m_resp[p].err); end
            end
        end
        in_valid = 1'b0; port_ack = '0; stall_clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_hol_stall();
        test_bad_port();
        test_ack_dispatch();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
